// File: rtl/bjack_score_disp_ctrl.sv
// bjack_score_disp_ctrl
// Shares one external binary-to-BCD decoder between the player and dealer
// score units. A round-robin arbiter grants one requester at a time, the
// converted digits and a bust flag are stored per requester, and the four
// stored digits are scanned onto a time-multiplexed display.
module bjack_score_disp_ctrl #(
  parameter int SCAN_DIV   = 16,
  parameter int BUST_LIMIT = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_P,
  input  logic [4:0] BIN_P,
  input  logic       REQ_D,
  input  logic [4:0] BIN_D,
  output logic       ACK_P,
  output logic       ACK_D,
  output logic [4:0] DEC_BIN,
  input  logic [1:0] DEC_H,
  input  logic [3:0] DEC_L,
  output logic       BUSY,
  output logic       BUST_P,
  output logic       BUST_D,
  output logic [3:0] DIG_SEL,
  output logic [3:0] SEG_BCD
);

  // Prescaler width; SCAN_DIV is at least 2 so this is at least one bit.
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LP_PRESC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [4:0]    LP_BUST_LIMIT = 5'(BUST_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Conversion sequencing state
  state_t      r_state;
  logic [4:0]  r_dec_bin;
  logic        r_gnt_d;     // 1: dealer holds the current grant
  logic        r_last_d;    // 1: dealer was granted most recently
  logic        r_ack_p;
  logic        r_ack_d;
  logic        r_busy;

  // Stored digits and bust flags per requester
  logic [1:0]  r_p_h;
  logic [3:0]  r_p_l;
  logic [1:0]  r_d_h;
  logic [3:0]  r_d_l;
  logic        r_bust_p;
  logic        r_bust_d;

  // Display scan state
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_dig_sel;
  logic [3:0]    r_seg;

  // Combinational helpers
  logic        w_any_req;
  logic        w_pick_d;
  logic        w_bust;
  logic        w_wrap;
  logic [1:0]  w_idx_nxt;

  // One-hot digit enable for a scan slot.
  function automatic logic [3:0] f_dig_onehot(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = 4'b0001;
      2'd1:    sel = 4'b0010;
      2'd2:    sel = 4'b0100;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0001;
    endcase
    return sel;
  endfunction

  // BCD value shown in a scan slot: player units, player tens, dealer units, dealer tens.
  function automatic logic [3:0] f_seg_mux(
    input logic [1:0] idx,
    input logic [1:0] p_h,
    input logic [3:0] p_l,
    input logic [1:0] d_h,
    input logic [3:0] d_l
  );
    logic [3:0] seg;
    case (idx)
      2'd0:    seg = p_l;
      2'd1:    seg = {2'b00, p_h};
      2'd2:    seg = d_l;
      2'd3:    seg = {2'b00, d_h};
      default: seg = 4'd0;
    endcase
    return seg;
  endfunction

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_any_req = REQ_P | REQ_D;
    w_pick_d  = REQ_D & (~REQ_P | ~r_last_d);
    w_bust    = (r_dec_bin > LP_BUST_LIMIT);
  end

  // Scan slot that becomes active on the coming edge.
  always_comb begin
    w_wrap = (r_presc == LP_PRESC_MAX);
    if (w_wrap) begin
      w_idx_nxt = r_idx + 2'd1;
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Grant / convert / acknowledge sequencer with per-requester digit storage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_dec_bin <= 5'd0;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b1;
      r_ack_p   <= 1'b0;
      r_ack_d   <= 1'b0;
      r_busy    <= 1'b0;
      r_p_h     <= 2'd0;
      r_p_l     <= 4'd0;
      r_d_h     <= 2'd0;
      r_d_l     <= 4'd0;
      r_bust_p  <= 1'b0;
      r_bust_d  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack_p <= 1'b0;
          r_ack_d <= 1'b0;
          if (w_any_req) begin
            // Operand is latched here, so later BIN changes cannot disturb it.
            r_dec_bin <= w_pick_d ? BIN_D : BIN_P;
            r_gnt_d   <= w_pick_d;
            r_last_d  <= w_pick_d;
            r_busy    <= 1'b1;
            r_state   <= ST_CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CONV: begin
          // Decoder outputs have settled a full cycle after DEC_BIN was registered.
          if (r_gnt_d) begin
            r_d_h    <= DEC_H;
            r_d_l    <= DEC_L;
            r_bust_d <= w_bust;
            r_ack_d  <= 1'b1;
            r_ack_p  <= 1'b0;
          end else begin
            r_p_h    <= DEC_H;
            r_p_l    <= DEC_L;
            r_bust_p <= w_bust;
            r_ack_p  <= 1'b1;
            r_ack_d  <= 1'b0;
          end
          r_busy  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ack_p <= 1'b0;
          r_ack_d <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack_p <= 1'b0;
          r_ack_d <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running display scan; output digit refreshes every edge so fresh
  // conversions appear as soon as their slot is (or stays) active.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_presc   <= '0;
      r_idx     <= 2'd0;
      r_dig_sel <= 4'b0001;
      r_seg     <= 4'd0;
    end else begin
      if (w_wrap) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
      end
      r_idx     <= w_idx_nxt;
      r_dig_sel <= f_dig_onehot(w_idx_nxt);
      r_seg     <= f_seg_mux(w_idx_nxt, r_p_h, r_p_l, r_d_h, r_d_l);
    end
  end

  assign ACK_P   = r_ack_p;
  assign ACK_D   = r_ack_d;
  assign DEC_BIN = r_dec_bin;
  assign BUSY    = r_busy;
  assign BUST_P  = r_bust_p;
  assign BUST_D  = r_bust_d;
  assign DIG_SEL = r_dig_sel;
  assign SEG_BCD = r_seg;

endmodule

// File: tb/tb_bjack_score_disp_ctrl.sv
// Directed bench for bjack_score_disp_ctrl with a scoreboard of expected
// conversions and a behavioural model of the external BCD decoder.
module tb_bjack_score_disp_ctrl;

  localparam int SCAN_DIV = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_P;
  logic [4:0] BIN_P;
  logic       REQ_D;
  logic [4:0] BIN_D;
  logic       ACK_P;
  logic       ACK_D;
  logic [4:0] DEC_BIN;
  logic [1:0] DEC_H;
  logic [3:0] DEC_L;
  logic       BUSY;
  logic       BUST_P;
  logic       BUST_D;
  logic [3:0] DIG_SEL;
  logic [3:0] SEG_BCD;

  bjack_score_disp_ctrl #(.SCAN_DIV(SCAN_DIV), .BUST_LIMIT(21)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_P(REQ_P), .BIN_P(BIN_P), .REQ_D(REQ_D), .BIN_D(BIN_D),
    .ACK_P(ACK_P), .ACK_D(ACK_D), .DEC_BIN(DEC_BIN),
    .DEC_H(DEC_H), .DEC_L(DEC_L), .BUSY(BUSY),
    .BUST_P(BUST_P), .BUST_D(BUST_D),
    .DIG_SEL(DIG_SEL), .SEG_BCD(SEG_BCD)
  );

  // External shared decoder
  assign DEC_H = 2'(DEC_BIN / 5'd10);
  assign DEC_L = 4'(DEC_BIN % 5'd10);

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       is_d;
    logic [4:0] bin;
    logic [1:0] h;
    logic [3:0] l;
    logic       bust;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model of the stored digits, updated as scoreboard entries retire
  logic [1:0] mdl_p_h, mdl_d_h;
  logic [3:0] mdl_p_l, mdl_d_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [4:0] bin, input logic [1:0] h,
                      input logic [3:0] l, input logic bust);
    exp_t e;
    e.is_d = is_d; e.bin = bin; e.h = h; e.l = l; e.bust = bust;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input string tag);
    RESET = 1'b1;
    REQ_P = 1'b0;
    REQ_D = 1'b0;
    tick();
    chk({tag, "_dec_bin"}, 32'(DEC_BIN), 32'd0);
    chk({tag, "_ack"}, 32'({ACK_P, ACK_D}), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_bust"}, 32'({BUST_P, BUST_D}), 32'd0);
    chk({tag, "_dig_sel"}, 32'(DIG_SEL), 32'd1);
    chk({tag, "_seg"}, 32'(SEG_BCD), 32'd0);
    mdl_p_h = 2'd0; mdl_p_l = 4'd0; mdl_d_h = 2'd0; mdl_d_l = 4'd0;
    tick();
    RESET = 1'b0;
  endtask

  // Retire one scoreboard entry: wait for its ACK, check latency, pulse width and flags.
  task automatic wait_ack(input string tag, input int exp_lat, input bit drop);
    exp_t e;
    int n;
    n = 0;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    while (!(ACK_P || ACK_D) && n < 8) begin
      tick();
      n++;
      if (n == 1 && !(ACK_P || ACK_D)) chk({tag, "_busy_grant"}, 32'(BUSY), 32'd1);
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_ack_who"}, 32'({ACK_P, ACK_D}), e.is_d ? 32'd1 : 32'd2);
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_dec_bin"}, 32'(DEC_BIN), 32'(e.bin));
    chk({tag, "_bust"}, 32'(e.is_d ? BUST_D : BUST_P), 32'(e.bust));
    if (e.is_d) begin
      mdl_d_h = e.h; mdl_d_l = e.l;
    end else begin
      mdl_p_h = e.h; mdl_p_l = e.l;
    end
    tick();
    chk({tag, "_ack_pulse"}, 32'({ACK_P, ACK_D}), 32'd0);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    if (drop) begin
      if (e.is_d) REQ_D = 1'b0;
      else        REQ_P = 1'b0;
    end
  endtask

  // Observe one full scan and compare every slot against the digit model.
  task automatic check_disp(input string tag);
    logic [3:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = 4'hF;
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      case (DIG_SEL)
        4'b0001: s[0] = SEG_BCD;
        4'b0010: s[1] = SEG_BCD;
        4'b0100: s[2] = SEG_BCD;
        4'b1000: s[3] = SEG_BCD;
        default: chk({tag, "_onehot"}, 32'(DIG_SEL), 32'd1);
      endcase
      tick();
    end
    chk({tag, "_p_l"}, 32'(s[0]), 32'(mdl_p_l));
    chk({tag, "_p_h"}, 32'(s[1]), 32'({2'b00, mdl_p_h}));
    chk({tag, "_d_l"}, 32'(s[2]), 32'(mdl_d_l));
    chk({tag, "_d_h"}, 32'(s[3]), 32'({2'b00, mdl_d_h}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [4:0] bv [7];
    logic [1:0] hv [7];
    logic [3:0] lv [7];
    logic       kv [7];
    logic [3:0] seq [4];
    logic [3:0] prev;
    int n;

    BIN_P = 5'd0;
    BIN_D = 5'd0;
    apply_reset("rst0");

    // Single player conversion
    push(1'b0, 5'd17, 2'd1, 4'd7, 1'b0);
    BIN_P = 5'd17; REQ_P = 1'b1;
    wait_ack("t1", 2, 1'b1);
    check_disp("t1_disp");

    // BIN change after the grant edge is ignored
    push(1'b0, 5'd20, 2'd2, 4'd0, 1'b0);
    BIN_P = 5'd20; REQ_P = 1'b1;
    tick();
    BIN_P = 5'd9;
    wait_ack("binchg", 1, 1'b1);
    check_disp("binchg_disp");

    // Simultaneous requests after reset: player first
    apply_reset("rst1");
    push(1'b0, 5'd21, 2'd2, 4'd1, 1'b0);
    push(1'b1, 5'd25, 2'd2, 4'd5, 1'b1);
    BIN_P = 5'd21; BIN_D = 5'd25; REQ_P = 1'b1; REQ_D = 1'b1;
    wait_ack("t2p", 2, 1'b1);
    wait_ack("t2d", 2, 1'b1);
    check_disp("t2_disp");

    // Continuous dual requests alternate P, D, P, D, P, D
    BIN_P = 5'd5; BIN_D = 5'd30;
    for (int g = 0; g < 3; g++) begin
      push(1'b0, 5'd5, 2'd0, 4'd5, 1'b0);
      push(1'b1, 5'd30, 2'd3, 4'd0, 1'b1);
    end
    REQ_P = 1'b1; REQ_D = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_ack($sformatf("t3g%0d", g), 2, (g >= 4));
    end
    check_disp("t3_disp");

    // Dealer boundary scores
    bv = '{5'd0, 5'd9, 5'd10, 5'd19, 5'd20, 5'd22, 5'd31};
    hv = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    lv = '{4'd0, 4'd9, 4'd0, 4'd9, 4'd0, 4'd2, 4'd1};
    kv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      push(1'b1, bv[i], hv[i], lv[i], kv[i]);
      BIN_D = bv[i]; REQ_D = 1'b1;
      wait_ack($sformatf("t4v%0d", bv[i]), 2, 1'b1);
      check_disp($sformatf("t4v%0d_disp", bv[i]));
    end

    // Scan sequence with player 18, dealer 7
    push(1'b0, 5'd18, 2'd1, 4'd8, 1'b0);
    BIN_P = 5'd18; REQ_P = 1'b1;
    wait_ack("t5p", 2, 1'b1);
    push(1'b1, 5'd7, 2'd0, 4'd7, 1'b0);
    BIN_D = 5'd7; REQ_D = 1'b1;
    wait_ack("t5d", 2, 1'b1);
    seq = '{4'd8, 4'd1, 4'd7, 4'd0};
    n = 0;
    prev = DIG_SEL;
    while (!(prev != 4'b0001 && DIG_SEL == 4'b0001) && n < 40) begin
      prev = DIG_SEL;
      tick();
      n++;
    end
    chk("t5_align", 32'(n < 40), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_sel%0d", i), 32'(DIG_SEL), 32'(4'b0001 << (i / 4)));
      chk($sformatf("t5_seg%0d", i), 32'(SEG_BCD), 32'(seq[i / 4]));
      tick();
    end

    // Reset during a dealer conversion aborts it
    BIN_D = 5'd13; REQ_D = 1'b1;
    tick();
    chk("t6_busy_grant", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    chk("t6_rst_ack", 32'({ACK_P, ACK_D}), 32'd0);
    chk("t6_rst_dig_sel", 32'(DIG_SEL), 32'd1);
    chk("t6_rst_seg", 32'(SEG_BCD), 32'd0);
    chk("t6_rst_bust", 32'({BUST_P, BUST_D}), 32'd0);
    chk("t6_rst_dec_bin", 32'(DEC_BIN), 32'd0);
    tick();
    chk("t6_no_ack", 32'({ACK_P, ACK_D}), 32'd0);
    chk("t6_held_seg", 32'(SEG_BCD), 32'd0);
    mdl_p_h = 2'd0; mdl_p_l = 4'd0; mdl_d_h = 2'd0; mdl_d_l = 4'd0;
    RESET = 1'b0;
    push(1'b1, 5'd13, 2'd1, 4'd3, 1'b0);
    wait_ack("t6_re", 2, 1'b1);
    check_disp("t6_disp");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
